// File: rtl/rf_wr_arbiter_if.sv
// Write-port arbitration bundle: writeback and MDU result inputs, decode
// scoreboard, pipeline stall and the register file write port.
interface rf_wr_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic                   i_wb_wr_en;
    logic [ADDR_W-1:0]      i_wb_wr_addr;
    logic [DATA_W-1:0]      i_wb_wr_data;
    logic                   i_mdu_valid;
    logic [ADDR_W-1:0]      i_mdu_addr;
    logic [DATA_W-1:0]      i_mdu_data;
    logic                   o_mdu_ready;
    logic                   i_issue_valid;
    logic [ADDR_W-1:0]      i_issue_addr;
    logic [2**ADDR_W-1:0]   o_pending;
    logic                   o_stall;
    logic                   o_rf_wr_en;
    logic [ADDR_W-1:0]      o_rf_wr_addr;
    logic [DATA_W-1:0]      o_rf_wr_data;

    modport master (
        output i_wb_wr_en, i_wb_wr_addr, i_wb_wr_data,
        output i_mdu_valid, i_mdu_addr, i_mdu_data,
        output i_issue_valid, i_issue_addr,
        input  o_mdu_ready, o_pending, o_stall,
        input  o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data
    );

    modport slave (
        input  i_wb_wr_en, i_wb_wr_addr, i_wb_wr_data,
        input  i_mdu_valid, i_mdu_addr, i_mdu_data,
        input  i_issue_valid, i_issue_addr,
        output o_mdu_ready, o_pending, o_stall,
        output o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data
    );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Register file write-port arbiter: writeback has priority, MDU results queue
// in a FIFO with a starvation-triggered forced drain and a pending scoreboard.
module rf_wr_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    rf_wr_arbiter_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam int NREG  = 2**ADDR_W;

    typedef enum logic {NORMAL, FORCE_DRAIN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t            state;
    entry_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [STV_W-1:0]  starve_cnt;
    logic              alive;
    logic [NREG-1:0]   pending;
    logic              rf_wr_en_q;
    logic [ADDR_W-1:0] rf_wr_addr_q;
    logic [DATA_W-1:0] rf_wr_data_q;

    logic              fifo_empty;
    logic              fifo_full;
    logic              wb_win;
    logic              pop;
    logic              push;
    logic              push_store;
    logic              grant;
    entry_t            head;
    entry_t            grant_entry;
    logic [STV_W-1:0]  starve_next;
    logic [NREG-1:0]   pending_next;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign head       = fifo_mem[rd_ptr];

    // FORCE_DRAIN masks the writeback request, which turns the pop unconditional.
    assign wb_win     = (state == NORMAL) && bus.i_wb_wr_en && (bus.i_wb_wr_addr != '0);
    assign pop        = !fifo_empty && !wb_win;
    assign grant      = wb_win || pop;
    assign push       = bus.i_mdu_valid && bus.o_mdu_ready;
    assign push_store = push && (bus.i_mdu_addr != '0);

    assign bus.o_mdu_ready  = alive && !fifo_full;
    assign bus.o_stall      = (state == FORCE_DRAIN);
    assign bus.o_pending    = pending;
    assign bus.o_rf_wr_en   = rf_wr_en_q;
    assign bus.o_rf_wr_addr = rf_wr_addr_q;
    assign bus.o_rf_wr_data = rf_wr_data_q;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        grant_entry = head;
        if (wb_win) begin
            grant_entry.addr = bus.i_wb_wr_addr;
            grant_entry.data = bus.i_wb_wr_data;
        end

        starve_next = '0;
        if (wb_win && !fifo_empty) starve_next = starve_cnt + 1'b1;

        pending_next = pending;
        if (pop) pending_next[head.addr] = 1'b0;
        if (bus.i_issue_valid && (bus.i_issue_addr != '0)) pending_next[bus.i_issue_addr] = 1'b1;
        pending_next[0] = 1'b0;
    end

    // NOTE: payload storage has no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_store) fifo_mem[wr_ptr] <= '{addr: bus.i_mdu_addr, data: bus.i_mdu_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= NORMAL;
            starve_cnt   <= '0;
            alive        <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            pending      <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
        end else begin
            alive <= 1'b1;

            if (starve_next == STV_W'(STARVE_LIMIT)) begin
                state      <= FORCE_DRAIN;
                starve_cnt <= '0;
            end else begin
                state      <= NORMAL;
                starve_cnt <= starve_next;
            end

            // Power-of-two depth lets the pointers wrap by plain overflow.
            if (push_store) wr_ptr <= wr_ptr + 1'b1;
            if (pop)        rd_ptr <= rd_ptr + 1'b1;
            case ({push_store, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            pending    <= pending_next;
            rf_wr_en_q <= grant;
            if (grant) begin
                rf_wr_addr_q <= grant_entry.addr;
                rf_wr_data_q <= grant_entry.data;
            end
        end
    end
endmodule
